// File: rtl/tty_arbiter.sv
// Shares one teletype between CPU writes/clears and keyboard echo: one command
// per transaction, then paces the next one on the TTY_ready fall/rise handshake.
module tty_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic [6:0] cpu_data,
  input  logic       cpu_clear,
  output logic       cpu_ack,
  input  logic       kb_req,
  input  logic [6:0] kb_data,
  output logic       kb_ack,
  input  logic       TTY_ready,
  output logic [6:0] TTY_data,
  output logic       TTY_en,
  output logic       TTY_clear,
  output logic       busy,
  output logic [1:0] o_dbg_state
);

  // Handshake: a requester raises req (cpu_clear counts as a CPU req) with its
  // data and holds both until its one-cycle ack; requests are sampled only in
  // IDLE, so a req still high after its ack is a fresh command.

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_LOW  = 2'd2,
    ST_WAIT_HIGH = 2'd3
  } state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYCLES);

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_next;
  logic       r_last_kb;
  logic       w_last_kb_next;
  logic       r_armed;
  logic [6:0] r_tty_data;
  logic [6:0] w_tty_data_next;
  logic       r_tty_en;
  logic       w_tty_en_next;
  logic       r_tty_clear;
  logic       w_tty_clear_next;
  logic       r_cpu_ack;
  logic       w_cpu_ack_next;
  logic       r_kb_ack;
  logic       w_kb_ack_next;
  logic       r_busy;
  logic       w_busy_next;

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_last_kb_next   = r_last_kb;
    w_tty_data_next  = r_tty_data;
    w_tty_en_next    = 1'b0;
    w_tty_clear_next = 1'b0;
    w_cpu_ack_next   = 1'b0;
    w_kb_ack_next    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // r_armed keeps the first grant off the first edge after reset release
        if (r_armed && TTY_ready) begin
          if (cpu_clear) begin
            w_state_next     = ST_ISSUE;
            w_tty_clear_next = 1'b1;
            w_cpu_ack_next   = 1'b1;
          end else if (cpu_req && (!kb_req || r_last_kb)) begin
            w_state_next    = ST_ISSUE;
            w_tty_en_next   = 1'b1;
            w_cpu_ack_next  = 1'b1;
            w_tty_data_next = cpu_data;
            w_last_kb_next  = 1'b0;
          end else if (kb_req) begin
            w_state_next    = ST_ISSUE;
            w_tty_en_next   = 1'b1;
            w_kb_ack_next   = 1'b1;
            w_tty_data_next = kb_data;
            w_last_kb_next  = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        w_state_next = ST_WAIT_LOW;
        w_cnt_next   = LP_TIMEOUT;
      end
      ST_WAIT_LOW: begin
        // Counter runs TIMEOUT_CYCLES down to 0; a device that never drops
        // ready is then assumed to have taken the command instantly.
        if (!TTY_ready) begin
          w_state_next = ST_WAIT_HIGH;
        end else if (r_cnt == 8'd0) begin
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      ST_WAIT_HIGH: begin
        if (TTY_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    w_busy_next = (w_state_next != ST_IDLE);
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 8'd0;
      r_last_kb   <= 1'b1;
      r_armed     <= 1'b0;
      r_tty_data  <= 7'd0;
      r_tty_en    <= 1'b0;
      r_tty_clear <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_kb_ack    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_last_kb   <= w_last_kb_next;
      r_armed     <= 1'b1;
      r_tty_data  <= w_tty_data_next;
      r_tty_en    <= w_tty_en_next;
      r_tty_clear <= w_tty_clear_next;
      r_cpu_ack   <= w_cpu_ack_next;
      r_kb_ack    <= w_kb_ack_next;
      r_busy      <= w_busy_next;
    end
  end

  assign TTY_data    = r_tty_data;
  assign TTY_en      = r_tty_en;
  assign TTY_clear   = r_tty_clear;
  assign cpu_ack     = r_cpu_ack;
  assign kb_ack      = r_kb_ack;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tty_arbiter.sv
// Bench for tty_arbiter: directed scenarios plus randomized requesters, checked
// every cycle against a timeline model of the arbiter's rules.
module tb_tty_arbiter;

  localparam int T = 15;

  logic       mclk = 1'b0;
  logic       reset;
  logic       cpu_req;
  logic [6:0] cpu_data;
  logic       cpu_clear;
  logic       cpu_ack;
  logic       kb_req;
  logic [6:0] kb_data;
  logic       kb_ack;
  logic       TTY_ready;
  logic [6:0] TTY_data;
  logic       TTY_en;
  logic       TTY_clear;
  logic       busy;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail = 0;
  int n_strobes = 0;
  int base;
  logic [7:0] exp_q[$];
  bit sb_on;
  bit rand_on;
  int renew_pct;

  // Reference model: a timeline of when the arbiter is free again
  int   cyc;
  int   m_free_at;
  int   m_strobe_cyc;
  bit   m_wait_rise;
  bit   m_last_kb;
  bit   m_armed;
  logic e_en, e_clr, e_cack, e_kack, e_busy;
  logic [6:0] e_data;

  always #5 mclk = ~mclk;

  tty_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .mclk        (mclk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_data    (cpu_data),
    .cpu_clear   (cpu_clear),
    .cpu_ack     (cpu_ack),
    .kb_req      (kb_req),
    .kb_data     (kb_data),
    .kb_ack      (kb_ack),
    .TTY_ready   (TTY_ready),
    .TTY_data    (TTY_data),
    .TTY_en      (TTY_en),
    .TTY_clear   (TTY_clear),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_free_at    = 0;
    m_strobe_cyc = -1000;
    m_wait_rise  = 1'b0;
    m_last_kb    = 1'b1;
    m_armed      = 1'b0;
    {e_en, e_clr, e_cack, e_kack, e_busy} = '0;
    e_data = 7'd0;
  endtask

  // Uses the inputs that the next rising edge will sample; predicts the
  // outputs of the cycle after that edge.
  task automatic model_step();
    bit idle_now;
    if (!reset) begin
      model_reset();
      cyc++;
      return;
    end
    idle_now = (cyc >= m_free_at) && !m_wait_rise;
    if (m_wait_rise) begin
      if (TTY_ready) begin
        m_wait_rise = 1'b0;
        m_free_at   = cyc + 1;
      end
    end else if (cyc > m_strobe_cyc && cyc < m_free_at && !TTY_ready) begin
      m_wait_rise = 1'b1;
    end
    {e_en, e_clr, e_cack, e_kack} = '0;
    if (idle_now && m_armed && TTY_ready && (cpu_clear || cpu_req || kb_req)) begin
      if (cpu_clear) begin
        e_clr  = 1'b1;
        e_cack = 1'b1;
      end else if (cpu_req && (!kb_req || m_last_kb)) begin
        e_en = 1'b1; e_cack = 1'b1; e_data = cpu_data; m_last_kb = 1'b0;
      end else begin
        e_en = 1'b1; e_kack = 1'b1; e_data = kb_data; m_last_kb = 1'b1;
      end
      m_strobe_cyc = cyc + 1;
      m_free_at    = cyc + 1 + T + 2;
    end
    m_armed = 1'b1;
    cyc++;
    e_busy = !((cyc >= m_free_at) && !m_wait_rise);
  endtask

  task automatic drive_random();
    if (!cpu_req && $urandom_range(0, 3) == 0) begin
      cpu_req  = 1'b1;
      cpu_data = 7'($urandom);
    end
    if (!cpu_clear && $urandom_range(0, 19) == 0) cpu_clear = 1'b1;
    if (!kb_req && $urandom_range(0, 3) == 0) begin
      kb_req  = 1'b1;
      kb_data = 7'($urandom);
    end
    if ($urandom_range(0, 99) == 0) cpu_req = 1'b0;
    if ($urandom_range(0, 99) == 0) kb_req = 1'b0;
    if ($urandom_range(0, 7) == 0) TTY_ready = ~TTY_ready;
    reset = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
  endtask

  task automatic tick();
    logic [7:0] obs;
    model_step();
    @(posedge mclk);
    @(negedge mclk);
    check_eq("ctl", 32'({busy, cpu_ack, kb_ack, TTY_clear, TTY_en}),
             32'({e_busy, e_cack, e_kack, e_clr, e_en}));
    check_eq("data", 32'(TTY_data), 32'(e_data));
    if (TTY_en || TTY_clear) begin
      n_strobes++;
      obs = TTY_clear ? 8'h80 : {1'b0, TTY_data};
      if (sb_on) begin
        if (exp_q.size() == 0) check_eq("sb_unexpected", 32'({1'b1, obs}), 32'd0);
        else check_eq("sb_cmd", 32'(obs), 32'(exp_q.pop_front()));
      end
    end
    if (cpu_ack) begin
      if (cpu_clear) cpu_clear = 1'b0;
      else if ($urandom_range(0, 99) < renew_pct) begin
        if (rand_on) cpu_data = 7'($urandom);
      end else cpu_req = 1'b0;
    end
    if (kb_ack) begin
      if ($urandom_range(0, 99) < renew_pct) begin
        if (rand_on) kb_data = 7'($urandom);
      end else kb_req = 1'b0;
    end
    if (rand_on) drive_random();
  endtask

  task automatic wait_strobes(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && n_strobes < target; i++) tick();
    check_eq(tag, 32'(n_strobes >= target), 32'd1);
  endtask

  initial begin
    reset = 1'b0; cpu_req = 1'b0; cpu_clear = 1'b0; kb_req = 1'b0;
    cpu_data = 7'd0; kb_data = 7'd0; TTY_ready = 1'b1;
    sb_on = 1'b0; rand_on = 1'b0; renew_pct = 0; cyc = 0;
    model_reset();
    repeat (2) @(negedge mclk);
    check_eq("rst_outs", 32'({busy, cpu_ack, kb_ack, TTY_clear, TTY_en, TTY_data}), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    sb_on = 1'b1;

    // Single keyboard char with ready held high
    exp_q.push_back(8'h33);
    base = n_strobes;
    reset = 1'b1; kb_req = 1'b1; kb_data = 7'h33;
    repeat (T + 6) tick();
    check_eq("t1_strobes", 32'(n_strobes - base), 32'd1);
    check_eq("t1_idle", 32'(busy), 32'd0);

    // Simultaneous requests held continuously alternate, CPU first
    exp_q.push_back(8'h48); exp_q.push_back(8'h69);
    exp_q.push_back(8'h48); exp_q.push_back(8'h69);
    base = n_strobes;
    renew_pct = 100;
    cpu_req = 1'b1; cpu_data = 7'h48; kb_req = 1'b1; kb_data = 7'h69;
    wait_strobes(base + 4, 100, "t2_four_issued");
    renew_pct = 0; cpu_req = 1'b0; kb_req = 1'b0;
    repeat (T + 4) tick();

    // Clear wins over a simultaneous char, char follows
    exp_q.push_back(8'h80); exp_q.push_back(8'h41);
    base = n_strobes;
    cpu_clear = 1'b1; cpu_req = 1'b1; cpu_data = 7'h41;
    wait_strobes(base + 2, 60, "t3_two_issued");
    repeat (T + 4) tick();

    // Ready low in IDLE blocks a pending request
    exp_q.push_back(8'h37);
    base = n_strobes;
    TTY_ready = 1'b0; kb_req = 1'b1; kb_data = 7'h37;
    repeat (10) tick();
    check_eq("t5_quiet", 32'(n_strobes - base), 32'd0);
    TTY_ready = 1'b1;
    wait_strobes(base + 1, 5, "t5_go");
    repeat (T + 4) tick();

    // Ready falls two cycles after the strobe and stays low for 40 cycles
    exp_q.push_back(8'h35); exp_q.push_back(8'h36);
    base = n_strobes;
    kb_req = 1'b1; kb_data = 7'h35;
    wait_strobes(base + 1, 5, "t4_first");
    cpu_req = 1'b1; cpu_data = 7'h36;
    tick(); tick();
    TTY_ready = 1'b0;
    repeat (40) tick();
    check_eq("t4_quiet", 32'(n_strobes - base), 32'd1);
    TTY_ready = 1'b1;
    wait_strobes(base + 2, 5, "t4_resume");

    // Reset asserted while waiting for ready to rise
    exp_q.push_back(8'h52);
    base = n_strobes;
    kb_req = 1'b1; kb_data = 7'h52;
    wait_strobes(base + 1, 25, "t6_issue");
    tick();
    TTY_ready = 1'b0;
    repeat (3) tick();
    check_eq("t6_waiting", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("rst_async", 32'({busy, cpu_ack, kb_ack, TTY_clear, TTY_en, TTY_data}), 32'd0);
    repeat (3) tick();
    TTY_ready = 1'b1; reset = 1'b1;
    base = n_strobes;
    repeat (25) tick();
    check_eq("t6_no_reissue", 32'(n_strobes - base), 32'd0);
    check_eq("sb_left", 32'(exp_q.size()), 32'd0);
    sb_on = 1'b0;

    // Randomized traffic, ready toggling, occasional resets
    rand_on = 1'b1; renew_pct = 50;
    repeat (3000) tick();
    rand_on = 1'b0; renew_pct = 0;
    cpu_req = 1'b0; cpu_clear = 1'b0; kb_req = 1'b0; TTY_ready = 1'b1; reset = 1'b1;
    repeat (T + 6) tick();
    check_eq("final_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
